// File: rtl/cordic_sched_pkg.sv
// Shared types and helpers for the CORDIC job scheduler: mode codes, FSM
// state encoding and mode-to-result-count mapping.
package cordic_sched_pkg;

    localparam logic [7:0] MODE_SINCOS   = 8'd1;
    localparam logic [7:0] MODE_SINHCOSH = 8'd2;
    localparam logic [7:0] MODE_TANH     = 8'd3;
    localparam logic [7:0] MODE_ASINACOS = 8'd4;
    localparam logic [7:0] MODE_EXP      = 8'd5;
    localparam logic [7:0] MODE_LN       = 8'd6;
    localparam logic [7:0] MODE_SQRT     = 8'd7;
    localparam logic [7:0] MODE_ARCTAN   = 8'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_t;

    function automatic logic mode_is_valid(input logic [7:0] mode);
        return (mode >= MODE_SINCOS) && (mode <= MODE_ARCTAN);
    endfunction

    function automatic logic [1:0] mode_nres(input logic [7:0] mode);
        logic [1:0] n;
        case (mode)
            MODE_SINCOS, MODE_SINHCOSH, MODE_ASINACOS: n = 2'd2;
            MODE_TANH:                                 n = 2'd3;
            default:                                   n = 2'd1;
        endcase
        return n;
    endfunction

    // One-hot unit select; bit m-1 for mode m, zero for unknown modes.
    function automatic logic [7:0] mode_call(input logic [7:0] mode);
        logic [7:0] c;
        c = 8'd0;
        if (mode_is_valid(mode)) c = 8'd1 << (mode - 8'd1);
        return c;
    endfunction

endpackage

// File: rtl/cordic_job_scheduler_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or above the pointer,
// wrapping around; grant is one-hot, index is the encoded winner.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [2:0]         i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [2:0]         o_idx
);

    logic [7:0] w_req8;
    logic       w_found;
    logic [3:0] w_sum;

    assign w_req8 = 8'(i_req);

    always_comb begin
        w_found = 1'b0;
        w_sum   = 4'd0;
        o_idx   = 3'd0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_sum = {1'b0, i_ptr} + 4'(j);
            if (w_sum >= 4'(NUM_REQ)) w_sum = w_sum - 4'(NUM_REQ);
            if (!w_found && w_req8[w_sum[2:0]]) begin
                w_found = 1'b1;
                o_idx   = w_sum[2:0];
            end
        end
        for (int g = 0; g < NUM_REQ; g++) begin
            o_grant[g] = w_found && (o_idx == 3'(g));
        end
    end

endmodule

// File: rtl/cordic_job_scheduler.sv
// Shares one bank of CORDIC units between NUM_REQ requesters: round-robin
// accept, level-high unit call until done or timeout, then a tagged response.
module cordic_job_scheduler
    import cordic_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*8-1:0]      req_mode,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [7:0]                eng_call,
    output logic [DATA_W-1:0]         eng_data,
    output logic [DATA_W-1:0]         eng_data2,
    input  logic [7:0]                eng_done,
    input  logic [DATA_W-1:0]         eng_r0,
    input  logic [DATA_W-1:0]         eng_r1,
    input  logic [DATA_W-1:0]         eng_r2,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [2:0]                rsp_id,
    output logic [7:0]                rsp_mode,
    output logic [1:0]                rsp_nres,
    output logic [DATA_W-1:0]         rsp_d0,
    output logic [DATA_W-1:0]         rsp_d1,
    output logic [DATA_W-1:0]         rsp_d2,
    output logic                      rsp_err,
    output logic                      busy,
    output sched_state_t              dbg_state
);

    localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

    sched_state_t        r_state;
    logic [2:0]          r_ptr;
    logic [9:0]          r_cnt;
    logic [7:0]          r_call;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   r_data2;
    logic                r_rsp_valid;
    logic [2:0]          r_rsp_id;
    logic [7:0]          r_rsp_mode;
    logic [1:0]          r_rsp_nres;
    logic [DATA_W-1:0]   r_rsp_d0;
    logic [DATA_W-1:0]   r_rsp_d1;
    logic [DATA_W-1:0]   r_rsp_d2;
    logic                r_rsp_err;

    logic [NUM_REQ-1:0]  w_grant;
    logic [2:0]          w_win_idx;
    logic                w_accept;
    logic [7:0]          w_sel_mode;
    logic [DATA_W-1:0]   w_sel_a;
    logic [DATA_W-1:0]   w_sel_b;
    logic                w_done_hit;
    logic                w_timeout;
    logic [2:0]          w_ptr_next;
    logic [1:0]          w_nres;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_win_idx)
    );

    always_comb begin
        w_sel_mode = 8'd0;
        w_sel_a    = '0;
        w_sel_b    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_mode = req_mode[i*8 +: 8];
                w_sel_a    = req_a[i*DATA_W +: DATA_W];
                w_sel_b    = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    assign req_ready  = (r_state == ST_IDLE && !reset) ? w_grant : '0;
    assign w_accept   = |req_ready;
    // r_call is zero outside BUSY, so done bits of idle units never match.
    assign w_done_hit = |(eng_done & r_call);
    assign w_timeout  = (r_cnt == CNT_LAST);
    assign w_ptr_next = (w_win_idx == 3'(NUM_REQ - 1)) ? 3'd0 : w_win_idx + 3'd1;
    assign w_nres     = mode_nres(r_rsp_mode);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 3'd0;
            r_cnt       <= 10'd0;
            r_call      <= 8'd0;
            r_data      <= '0;
            r_data2     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 3'd0;
            r_rsp_mode  <= 8'd0;
            r_rsp_nres  <= 2'd0;
            r_rsp_d0    <= '0;
            r_rsp_d1    <= '0;
            r_rsp_d2    <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_ptr      <= w_ptr_next;
                        r_cnt      <= 10'd0;
                        r_data     <= w_sel_a;
                        r_data2    <= w_sel_b;
                        r_rsp_id   <= w_win_idx;
                        r_rsp_mode <= w_sel_mode;
                        if (mode_is_valid(w_sel_mode)) begin
                            r_call  <= mode_call(w_sel_mode);
                            r_state <= ST_BUSY;
                        end else begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_nres  <= 2'd1;
                            r_rsp_d0    <= '0;
                            r_rsp_d1    <= '0;
                            r_rsp_d2    <= '0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt + 10'd1;
                    if (w_done_hit) begin
                        r_call     <= 8'd0;
                        r_rsp_err  <= 1'b0;
                        r_rsp_nres <= w_nres;
                        r_rsp_d0   <= eng_r0;
                        r_rsp_d1   <= (w_nres >= 2'd2) ? eng_r1 : '0;
                        r_rsp_d2   <= (w_nres == 2'd3) ? eng_r2 : '0;
                        r_state    <= ST_DRAIN;
                    end else if (w_timeout) begin
                        r_call     <= 8'd0;
                        r_rsp_err  <= 1'b1;
                        r_rsp_nres <= 2'd1;
                        r_rsp_d0   <= '0;
                        r_rsp_d1   <= '0;
                        r_rsp_d2   <= '0;
                        r_state    <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cnt       <= 10'd0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign eng_call  = r_call;
    assign eng_data  = r_data;
    assign eng_data2 = r_data2;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_mode  = r_rsp_mode;
    assign rsp_nres  = r_rsp_nres;
    assign rsp_d0    = r_rsp_d0;
    assign rsp_d1    = r_rsp_d1;
    assign rsp_d2    = r_rsp_d2;
    assign rsp_err   = r_rsp_err;
    assign busy      = (r_state != ST_IDLE);
    assign dbg_state = r_state;

endmodule
